// File: rtl/burst_trigger_ctrl.sv
// Trigger controller for the arbitrary function generator: synchronised trigger
// edge, prescaled delay, then a gated burst of waveform playbacks.
module burst_trigger_ctrl #(
  parameter int DELAY_W    = 34,
  parameter int PRESCALE_W = 8,
  parameter int BURST_W    = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Trig_In,
  input  logic [1:0]            Mode,
  input  logic [DELAY_W-1:0]    Delay_Vin,
  input  logic [PRESCALE_W-1:0] Prescale_Vin,
  input  logic [BURST_W-1:0]    Burst_Vin,
  input  logic                  Ending_Sin,
  input  logic                  Abort,
  output logic                  Trig_Ctrl_Sout,
  output logic                  Trig_out,
  output logic                  Busy,
  output logic [BURST_W-1:0]    Burst_Left,
  output logic                  Trig_Miss
);

  typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;

  state_t                  state, state_nx;
  logic                    sync1, sync2, sync2_d, evt;
  logic [DELAY_W-1:0]      dly_lat, dly_cnt;
  logic [PRESCALE_W-1:0]   pre_lat, pre_cnt;
  logic [BURST_W-1:0]      burst_lat;
  logic                    rpt_lat, trig_pend;
  logic                    kill, start, enter_run, end_more, end_last, miss;

  assign evt = sync2 & ~sync2_d;

  always_comb begin
    kill      = Abort | (Mode == 2'b00);
    start     = (state == IDLE) & evt & ~kill;
    enter_run = (state == DELAY) & (dly_cnt == '0) & ~kill;
    end_more  = (state == RUN) & Ending_Sin & (Burst_Left > BURST_W'(1)) & ~kill;
    end_last  = (state == RUN) & Ending_Sin & (Burst_Left <= BURST_W'(1)) & ~kill;
    miss      = (state != IDLE) & evt & ~kill;
    state_nx  = state;
    if (kill) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (evt) state_nx = DELAY;
        DELAY:   if (dly_cnt == '0) state_nx = RUN;
        RUN:     if (end_last) state_nx = rpt_lat ? DELAY : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      state   <= state_nx;
      sync1   <= Trig_In;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  // Sequence parameters are captured once per trigger; the counters only ever
  // reload from these copies so later input changes cannot disturb a sequence.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      dly_lat   <= '0;
      pre_lat   <= '0;
      burst_lat <= '0;
      rpt_lat   <= 1'b0;
      dly_cnt   <= '0;
      pre_cnt   <= '0;
    end else if (start) begin
      dly_lat   <= Delay_Vin;
      pre_lat   <= Prescale_Vin;
      burst_lat <= (Mode == 2'b01 || Burst_Vin == '0) ? BURST_W'(1) : Burst_Vin;
      rpt_lat   <= (Mode == 2'b11);
      dly_cnt   <= Delay_Vin;
      pre_cnt   <= '0;
    end else if (end_last && rpt_lat) begin
      dly_cnt   <= dly_lat;
      pre_cnt   <= '0;
    end else if (state == DELAY && dly_cnt != '0) begin
      if (pre_cnt == pre_lat) begin
        pre_cnt <= '0;
        dly_cnt <= dly_cnt - DELAY_W'(1);
      end else begin
        pre_cnt <= pre_cnt + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Burst_Left     <= '0;
      trig_pend      <= 1'b0;
      Trig_out       <= 1'b0;
      Trig_Ctrl_Sout <= 1'b0;
      Busy           <= 1'b0;
      Trig_Miss      <= 1'b0;
    end else begin
      if (kill || end_last)  Burst_Left <= '0;
      else if (enter_run)    Burst_Left <= burst_lat;
      else if (end_more)     Burst_Left <= Burst_Left - BURST_W'(1);
      // Next playback starts one cycle after the end pulse of the previous one.
      trig_pend      <= end_more;
      Trig_out       <= (enter_run | trig_pend) & ~kill;
      Trig_Ctrl_Sout <= (state_nx == RUN);
      Busy           <= (state_nx != IDLE);
      Trig_Miss      <= miss;
    end
  end

endmodule

// File: tb/tb_burst_trigger_ctrl.sv
// Bench for burst_trigger_ctrl: directed scenarios plus randomized sequences
// whose timing is predicted from delay/burst arithmetic.
module tb_burst_trigger_ctrl;
  localparam int DW = 34, PW = 8, BW = 16;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Trig_In = 1'b0;
  logic [1:0]    Mode = 2'b00;
  logic [DW-1:0] Delay_Vin = '0;
  logic [PW-1:0] Prescale_Vin = '0;
  logic [BW-1:0] Burst_Vin = '0;
  logic          Ending_Sin = 1'b0;
  logic          Abort = 1'b0;
  logic          Trig_Ctrl_Sout, Trig_out, Busy, Trig_Miss;
  logic [BW-1:0] Burst_Left;

  int total = 0;
  int bad   = 0;

  burst_trigger_ctrl #(.DELAY_W(DW), .PRESCALE_W(PW), .BURST_W(BW)) dut (
    .Clock(Clock), .Reset(Reset), .Trig_In(Trig_In), .Mode(Mode),
    .Delay_Vin(Delay_Vin), .Prescale_Vin(Prescale_Vin), .Burst_Vin(Burst_Vin),
    .Ending_Sin(Ending_Sin), .Abort(Abort), .Trig_Ctrl_Sout(Trig_Ctrl_Sout),
    .Trig_out(Trig_out), .Busy(Busy), .Burst_Left(Burst_Left), .Trig_Miss(Trig_Miss)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // One full triggered sequence; expectations come from D*(P+1)+1 and the burst count.
  task automatic run_sequence(input logic [1:0] m, input int d, input int p, input int b);
    int dly, nb, left, gap;
    dly = d * (p + 1) + 1;
    nb  = (m == 2'b01) ? 1 : ((b == 0) ? 1 : b);
    Mode = m; Delay_Vin = DW'(d); Prescale_Vin = PW'(p); Burst_Vin = BW'(b);
    repeat (3) step();
    Trig_In = 1'b1; step();
    Trig_In = 1'b0; step();
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL seq_busy_early got=%0b exp=0", Busy); end
    step();
    total++; if (Busy !== 1'b1 || Trig_Ctrl_Sout !== 1'b0) begin bad++; $display("FAIL seq_busy_k2 busy=%0b ctrl=%0b exp busy=1 ctrl=0", Busy, Trig_Ctrl_Sout); end
    Delay_Vin = DW'($urandom); Prescale_Vin = PW'($urandom); Burst_Vin = BW'($urandom);
    for (int i = 1; i < dly; i++) begin
      step();
      total++; if (Busy !== 1'b1 || Trig_Ctrl_Sout !== 1'b0) begin bad++; $display("FAIL seq_delay cyc=%0d busy=%0b ctrl=%0b exp busy=1 ctrl=0", i, Busy, Trig_Ctrl_Sout); end
    end
    step();
    total++; if (Trig_Ctrl_Sout !== 1'b1 || Trig_out !== 1'b1 || Burst_Left !== BW'(nb)) begin
      bad++; $display("FAIL seq_run_entry ctrl=%0b trig=%0b left=%0d exp 1 1 %0d", Trig_Ctrl_Sout, Trig_out, Burst_Left, nb); end
    left = nb;
    while (left > 0) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step();
        total++; if (Trig_out !== 1'b0 || Trig_Ctrl_Sout !== 1'b1) begin bad++; $display("FAIL seq_gap trig=%0b ctrl=%0b exp 0 1", Trig_out, Trig_Ctrl_Sout); end
      end
      Ending_Sin = 1'b1; step(); Ending_Sin = 1'b0;
      left--;
      total++; if (Burst_Left !== BW'(left)) begin bad++; $display("FAIL seq_left got=%0d exp=%0d", Burst_Left, left); end
      if (left > 0) begin
        total++; if (Trig_Ctrl_Sout !== 1'b1 || Trig_out !== 1'b0) begin bad++; $display("FAIL seq_mid_end ctrl=%0b trig=%0b exp 1 0", Trig_Ctrl_Sout, Trig_out); end
        step();
        total++; if (Trig_out !== 1'b1) begin bad++; $display("FAIL seq_retrig got=%0b exp=1", Trig_out); end
      end else begin
        total++; if (Trig_Ctrl_Sout !== 1'b0 || Busy !== (m == 2'b11)) begin
          bad++; $display("FAIL seq_last ctrl=%0b busy=%0b exp 0 %0b", Trig_Ctrl_Sout, Busy, m == 2'b11); end
      end
    end
    if (m == 2'b11) begin
      Abort = 1'b1; step(); Abort = 1'b0;
      total++; if (Busy !== 1'b0 || Trig_Ctrl_Sout !== 1'b0) begin bad++; $display("FAIL seq_abort busy=%0b ctrl=%0b exp 0 0", Busy, Trig_Ctrl_Sout); end
    end else begin
      Ending_Sin = 1'b1; step(); Ending_Sin = 1'b0;
      total++; if (Burst_Left !== '0 || Trig_out !== 1'b0 || Busy !== 1'b0) begin
        bad++; $display("FAIL seq_extra_end left=%0d trig=%0b busy=%0b exp 0 0 0", Burst_Left, Trig_out, Busy); end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; #1;
    total++; if ({Trig_Ctrl_Sout, Trig_out, Busy, Trig_Miss} !== 4'b0 || Burst_Left !== '0) begin
      bad++; $display("FAIL reset_vals ctrl=%0b trig=%0b busy=%0b miss=%0b left=%0d exp all 0", Trig_Ctrl_Sout, Trig_out, Busy, Trig_Miss, Burst_Left); end
    repeat (2) step();
    Reset = 1'b0;
    Mode = 2'b10; Delay_Vin = 1; Prescale_Vin = 0; Burst_Vin = 2;
    repeat (3) step();
    Trig_In = 1'b1; step();
    Trig_In = 1'b0; repeat (4) step();
    total++; if (Trig_Ctrl_Sout !== 1'b1 || Burst_Left !== 16'd2) begin bad++; $display("FAIL reset_pre_run ctrl=%0b left=%0d exp 1 2", Trig_Ctrl_Sout, Burst_Left); end
    #3 Reset = 1'b1; #1;
    total++; if ({Trig_Ctrl_Sout, Trig_out, Busy, Trig_Miss} !== 4'b0 || Burst_Left !== '0) begin
      bad++; $display("FAIL reset_mid_run ctrl=%0b trig=%0b busy=%0b miss=%0b left=%0d exp all 0", Trig_Ctrl_Sout, Trig_out, Busy, Trig_Miss, Burst_Left); end
    repeat (2) step();
    Reset = 1'b0;
    run_sequence(2'b01, 2, 1, 0);
  endtask

  task automatic test_single();
    run_sequence(2'b01, 3, 1, 5);
  endtask

  task automatic test_burst();
    run_sequence(2'b10, 0, 0, 3);
    run_sequence(2'b10, 2, 2, 0);
  endtask

  task automatic test_miss();
    Mode = 2'b10; Delay_Vin = 4; Prescale_Vin = 1; Burst_Vin = 0;
    repeat (3) step();
    Trig_In = 1'b1; step();
    Trig_In = 1'b0; step(); step();
    Trig_In = 1'b1; step();
    Trig_In = 1'b0; step();
    total++; if (Trig_Miss !== 1'b0) begin bad++; $display("FAIL miss_early got=%0b exp=0", Trig_Miss); end
    step();
    total++; if (Trig_Miss !== 1'b1) begin bad++; $display("FAIL miss_delay got=%0b exp=1", Trig_Miss); end
    step();
    total++; if (Trig_Miss !== 1'b0) begin bad++; $display("FAIL miss_delay_len got=%0b exp=0", Trig_Miss); end
    repeat (5) step();
    total++; if (Trig_Ctrl_Sout !== 1'b1 || Trig_out !== 1'b1 || Burst_Left !== 16'd1) begin
      bad++; $display("FAIL miss_run_entry ctrl=%0b trig=%0b left=%0d exp 1 1 1", Trig_Ctrl_Sout, Trig_out, Burst_Left); end
    Trig_In = 1'b1; step();
    Trig_In = 1'b0; step(); step();
    total++; if (Trig_Miss !== 1'b1 || Trig_Ctrl_Sout !== 1'b1 || Burst_Left !== 16'd1) begin
      bad++; $display("FAIL miss_run miss=%0b ctrl=%0b left=%0d exp 1 1 1", Trig_Miss, Trig_Ctrl_Sout, Burst_Left); end
    step();
    total++; if (Trig_Miss !== 1'b0) begin bad++; $display("FAIL miss_run_len got=%0b exp=0", Trig_Miss); end
    // trigger edge lands in the same cycle as the final end pulse
    Trig_In = 1'b1; step();
    Trig_In = 1'b0; step();
    Ending_Sin = 1'b1; step(); Ending_Sin = 1'b0;
    total++; if (Trig_Miss !== 1'b1 || Busy !== 1'b0 || Trig_Ctrl_Sout !== 1'b0) begin
      bad++; $display("FAIL miss_final miss=%0b busy=%0b ctrl=%0b exp 1 0 0", Trig_Miss, Busy, Trig_Ctrl_Sout); end
    repeat (3) begin
      step();
      total++; if (Busy !== 1'b0) begin bad++; $display("FAIL miss_not_queued busy=%0b exp=0", Busy); end
    end
  endtask

  task automatic test_repeat();
    Mode = 2'b11; Delay_Vin = 5; Prescale_Vin = 0; Burst_Vin = 2;
    repeat (3) step();
    Trig_In = 1'b1; step();
    Trig_In = 1'b0; step(); step();
    Delay_Vin = 0;
    repeat (5) step();
    total++; if (Trig_Ctrl_Sout !== 1'b0) begin bad++; $display("FAIL rpt_latched_delay ctrl=%0b exp=0", Trig_Ctrl_Sout); end
    step();
    total++; if (Trig_Ctrl_Sout !== 1'b1 || Burst_Left !== 16'd2) begin bad++; $display("FAIL rpt_run1 ctrl=%0b left=%0d exp 1 2", Trig_Ctrl_Sout, Burst_Left); end
    Ending_Sin = 1'b1; step(); step(); Ending_Sin = 1'b0;
    total++; if (Trig_Ctrl_Sout !== 1'b0 || Busy !== 1'b1 || Burst_Left !== '0) begin
      bad++; $display("FAIL rpt_redelay ctrl=%0b busy=%0b left=%0d exp 0 1 0", Trig_Ctrl_Sout, Busy, Burst_Left); end
    repeat (5) step();
    total++; if (Trig_Ctrl_Sout !== 1'b0 || Busy !== 1'b1) begin bad++; $display("FAIL rpt_delay2 ctrl=%0b busy=%0b exp 0 1", Trig_Ctrl_Sout, Busy); end
    step();
    total++; if (Trig_Ctrl_Sout !== 1'b1 || Trig_out !== 1'b1 || Burst_Left !== 16'd2) begin
      bad++; $display("FAIL rpt_run2 ctrl=%0b trig=%0b left=%0d exp 1 1 2", Trig_Ctrl_Sout, Trig_out, Burst_Left); end
    Abort = 1'b1; step(); Abort = 1'b0;
    total++; if (Trig_Ctrl_Sout !== 1'b0 || Busy !== 1'b0 || Trig_out !== 1'b0 || Burst_Left !== '0) begin
      bad++; $display("FAIL rpt_abort ctrl=%0b busy=%0b trig=%0b left=%0d exp 0 0 0 0", Trig_Ctrl_Sout, Busy, Trig_out, Burst_Left); end
    // Mode off during DELAY also drops to IDLE
    Mode = 2'b10; Delay_Vin = 6;
    repeat (3) step();
    Trig_In = 1'b1; step();
    Trig_In = 1'b0; repeat (3) step();
    Mode = 2'b00; step();
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mode_off busy=%0b exp=0", Busy); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++)
      run_sequence(2'($urandom_range(1, 3)), $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4));
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_miss();
    test_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
